// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
// Operation encoding and small helpers used by RTL and benches.
package adder_pkg;

    typedef enum logic [0:0] {
        ADDER_OP_ADD = 1'b0,
        ADDER_OP_SUB = 1'b1
    } adder_op_t;

    // SUB is a + ~b + 1, so the op bit doubles as the carry-in.
    function automatic logic op_cin(adder_op_t op);
        return op == ADDER_OP_SUB;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bundle for pipelined_adder.
// slave is the adder side, master the producer/consumer side.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    import adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    adder_op_t        in_op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, in_op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );

    modport master (
        output in_valid, in_op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

endinterface

// File: rtl/adder_slice.sv
// One CHUNK-wide combinational slice of the carry chain.
// Also reports the carry into its MSB for signed overflow.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i}
                           + {{W{1'b0}}, cin_i};

    // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly.
    assign cmsb_o = sum_o[W-1] ^ a_i[W-1] ^ b_i[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one carry-chained slice per register stage,
// whole pipeline advances together under a valid/ready handshake.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int    WIDTH        = 32,
    parameter int    STAGES       = 4,
    parameter bit    DEBUG_ENABLE = 1'b0,
    parameter string DEBUG_NAME   = "UNKNOWN"
) (
    input logic              clock,
    input logic              reset,
    pipelined_adder_if.slave bus
);

    localparam int SAFE_ST = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK   = WIDTH / SAFE_ST;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % SAFE_ST) != 0) begin : g_bad
        $error("pipelined_adder: STAGES must divide WIDTH");
    end

    typedef struct packed {
        logic overflow;
        logic zero;
    } flags_t;

    logic             adv;
    logic             sub;
    logic [WIDTH-1:0] b_x;
    flags_t           flags_d;
    flags_t           flags_q;

    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign sub          = op_cin(bus.in_op);
    assign b_x          = sub ? ~bus.operand_b : bus.operand_b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        // Operands still to be summed, current slice in the low bits.
        logic [WIDTH-LO-1:0] pa;
        logic [WIDTH-LO-1:0] pb;
        logic [HI-1:0]       res_d;
        logic [HI-1:0]       res_q;
        logic [CHUNK-1:0]    sum;
        logic                cin;
        logic                cout;
        logic                cmsb;
        logic                vld_d;
        logic                vld_q;
        logic                cy_q;

        if (k == 0) begin : g_in
            assign pa    = bus.operand_a;
            assign pb    = b_x;
            assign cin   = sub;
            assign vld_d = bus.in_valid;
            assign res_d = sum;
        end else begin : g_mid
            always_ff @(posedge clock) begin
                if (adv) begin
                    pa <= g_stage[k-1].pa[WIDTH-LO+CHUNK-1:CHUNK];
                    pb <= g_stage[k-1].pb[WIDTH-LO+CHUNK-1:CHUNK];
                end
            end
            assign cin   = g_stage[k-1].cy_q;
            assign vld_d = g_stage[k-1].vld_q;
            assign res_d = {sum, g_stage[k-1].res_q};
        end

        adder_slice #(
            .W (CHUNK)
        ) u_slice (
            .a_i    (pa[CHUNK-1:0]),
            .b_i    (pb[CHUNK-1:0]),
            .cin_i  (cin),
            .sum_o  (sum),
            .cout_o (cout),
            .cmsb_o (cmsb)
        );

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= 1'b0;
                res_q <= '0;
                cy_q  <= 1'b0;
            end else if (adv) begin
                vld_q <= vld_d;
                res_q <= res_d;
                cy_q  <= cout;
            end
        end
    end

    assign flags_d.overflow = g_stage[STAGES-1].cmsb
                            ^ g_stage[STAGES-1].cout;
    assign flags_d.zero     = ~|g_stage[STAGES-1].res_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
        end else if (adv) begin
            flags_q <= flags_d;
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].vld_q;
    assign bus.result    = g_stage[STAGES-1].res_q;
    assign bus.carry_out = g_stage[STAGES-1].cy_q;
    assign bus.overflow  = flags_q.overflow;
    assign bus.zero      = flags_q.zero;

    if (DEBUG_ENABLE) begin : g_debug
        always @(posedge clock) begin
            if (!reset && bus.in_valid && adv)
                $display("[%s] accept op=%0d a=%h b=%h", DEBUG_NAME,
                         bus.in_op, bus.operand_a, bus.operand_b);
            if (!reset && bus.out_valid && bus.out_ready)
                $display("[%s] emit r=%h c=%b v=%b z=%b", DEBUG_NAME,
                         bus.result, bus.carry_out, bus.overflow, bus.zero);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and reference-model bench for pipelined_adder.
// Main instance is 32x4; three more cover the parameter sweep.
module tb_pipelined_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic        c;
        logic        ov;
        logic        z;
        logic [63:0] r;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    always #5 clock = ~clock;

    pipelined_adder_if #(.WIDTH(32)) if0 ();
    pipelined_adder_if #(.WIDTH(32)) if1 ();
    pipelined_adder_if #(.WIDTH(64)) if2 ();
    pipelined_adder_if #(.WIDTH(8))  if3 ();

    pipelined_adder #(.WIDTH(32), .STAGES(4), .DEBUG_ENABLE(1'b0),
                      .DEBUG_NAME("u0"))
        u0 (.clock(clock), .reset(reset), .bus(if0.slave));
    pipelined_adder #(.WIDTH(32), .STAGES(1), .DEBUG_ENABLE(1'b0),
                      .DEBUG_NAME("u1"))
        u1 (.clock(clock), .reset(reset), .bus(if1.slave));
    pipelined_adder #(.WIDTH(64), .STAGES(8), .DEBUG_ENABLE(1'b0),
                      .DEBUG_NAME("u2"))
        u2 (.clock(clock), .reset(reset), .bus(if2.slave));
    pipelined_adder #(.WIDTH(8), .STAGES(8), .DEBUG_ENABLE(1'b0),
                      .DEBUG_NAME("u3"))
        u3 (.clock(clock), .reset(reset), .bus(if3.slave));

    // Independent reference: sign rule for overflow, wide sum for carry.
    function automatic exp_t model(input int w, input logic s,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
        logic [64:0] m, aa, bb, sm;
        exp_t e;
        m    = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & m;
        bb   = {1'b0, (s ? ~b : b)} & m;
        sm   = aa + bb + {64'd0, s};
        e.r  = sm[63:0] & m[63:0];
        e.c  = sm[w];
        e.ov = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
        e.z  = (e.r == 64'd0);
        return e;
    endfunction

    function automatic exp_t got0();
        return {if0.carry_out, if0.overflow, if0.zero, 32'd0, if0.result};
    endfunction
    function automatic exp_t got1();
        return {if1.carry_out, if1.overflow, if1.zero, 32'd0, if1.result};
    endfunction
    function automatic exp_t got2();
        return {if2.carry_out, if2.overflow, if2.zero, if2.result};
    endfunction
    function automatic exp_t got3();
        return {if3.carry_out, if3.overflow, if3.zero, 56'd0, if3.result};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        nvec++;
        if (if0.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_out_valid got=%b want=0", if0.out_valid);
        end
        nvec++;
        if (if0.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_ready got=%b want=1", if0.in_ready);
        end
        nvec++;
        if (got0() !== exp_t'(0)) begin
            nerr++;
            $display("FAIL reset_regs got=%h want=0", got0());
        end
        nvec++;
        if ({if1.out_valid, if2.out_valid, if3.out_valid} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_sweep_valid got=%b%b%b want=000",
                     if1.out_valid, if2.out_valid, if3.out_valid);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        adder_op_t   op [6] = '{ADDER_OP_ADD, ADDER_OP_SUB, ADDER_OP_ADD,
                                ADDER_OP_ADD, ADDER_OP_SUB, ADDER_OP_SUB};
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'h00FF_FFFF, 32'h0000_0000, 32'h0000_0005};
        logic [31:0] vb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                32'h0000_0001, 32'h0000_0001, 32'h0000_0005};
        // {carry, overflow, zero, result}
        logic [34:0] ve [6] = '{{3'b101, 32'h0000_0000},
                                {3'b110, 32'h7FFF_FFFF},
                                {3'b010, 32'h8000_0000},
                                {3'b000, 32'h0100_0000},
                                {3'b000, 32'hFFFF_FFFF},
                                {3'b101, 32'h0000_0000}};
        for (int i = 0; i < 6; i++) begin
            int   lat;
            exp_t e;
            e = {ve[i][34:32], 32'd0, ve[i][31:0]};
            if0.out_ready = 1'b1;
            if0.in_valid  = 1'b1;
            if0.in_op     = op[i];
            if0.operand_a = va[i];
            if0.operand_b = vb[i];
            step();
            if0.in_valid = 1'b0;
            lat = 0;
            for (int c = 1; c <= 10; c++) begin
                if (if0.out_valid === 1'b1) begin
                    lat = c;
                    break;
                end
                step();
            end
            nvec++;
            if (lat != 4) begin
                nerr++;
                $display("FAIL dir%0d_latency got=%0d want=4", i, lat);
            end
            nvec++;
            if (got0() !== e) begin
                nerr++;
                $display("FAIL dir%0d_value got=%h want=%h", i, got0(), e);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t        q [$];
        int          iss = 0;
        int          rcv = 0;
        logic [31:0] a, b;
        logic        s, acc, hs;
        a = $urandom;
        b = $urandom;
        s = 1'($urandom % 2);
        for (int cyc = 0; cyc < 60 && rcv < 13; cyc++) begin
            if0.out_ready = !(cyc >= 12 && cyc < 15);
            if0.in_valid  = (iss < 13);
            if0.in_op     = adder_op_t'(s);
            if0.operand_a = a;
            if0.operand_b = b;
            #1;
            acc = if0.in_valid & if0.in_ready;
            hs  = if0.out_valid & if0.out_ready;
            if (cyc >= 12 && cyc < 15) begin
                nvec++;
                if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 ||
                    got0() !== q[0]) begin
                    nerr++;
                    $display("FAIL stall%0d got rdy=%b vld=%b r=%h want 0 1 %h",
                             cyc, if0.in_ready, if0.out_valid, got0(), q[0]);
                end
            end
            if (hs) begin
                nvec++;
                if (got0() !== q[0]) begin
                    nerr++;
                    $display("FAIL stream%0d_value got=%h want=%h",
                             rcv, got0(), q[0]);
                end
                if (rcv < 8) begin
                    nvec++;
                    if (cyc != 4 + rcv) begin
                        nerr++;
                        $display("FAIL stream%0d_cycle got=%0d want=%0d",
                                 rcv, cyc, 4 + rcv);
                    end
                end
                void'(q.pop_front());
                rcv++;
            end
            if (acc) q.push_back(model(32, s, {32'd0, a}, {32'd0, b}));
            step();
            if (acc) begin
                iss++;
                a = $urandom;
                b = $urandom;
                s = 1'($urandom % 2);
            end
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        nvec++;
        if (rcv != 13 || q.size() != 0) begin
            nerr++;
            $display("FAIL stream_count got=%0d left=%0d want=13 left=0",
                     rcv, q.size());
        end
        step();
    endtask

    task automatic test_reset_midflight();
        int   seen = 0;
        int   lat  = 0;
        exp_t e;
        if0.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if0.in_valid  = 1'b1;
            if0.in_op     = ADDER_OP_ADD;
            if0.operand_a = 32'h1000 + i;
            if0.operand_b = 32'h1;
            step();
        end
        if0.in_valid = 1'b0;
        reset = 1'b1;
        step();
        nvec++;
        if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL midreset_hs got vld=%b rdy=%b want 0 1",
                     if0.out_valid, if0.in_ready);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (if0.out_valid === 1'b1) seen++;
            step();
        end
        nvec++;
        if (seen != 0) begin
            nerr++;
            $display("FAIL midreset_leak got=%0d want=0", seen);
        end
        if0.in_valid  = 1'b1;
        if0.in_op     = ADDER_OP_SUB;
        if0.operand_a = 32'h0000_0010;
        if0.operand_b = 32'h0000_0003;
        e = {3'b100, 32'd0, 32'h0000_000D};
        step();
        if0.in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (if0.out_valid === 1'b1) begin
                lat = c;
                break;
            end
            step();
        end
        nvec++;
        if (lat != 4 || got0() !== e) begin
            nerr++;
            $display("FAIL midreset_next got lat=%0d r=%h want 4 %h",
                     lat, got0(), e);
        end
        step();
    endtask

    task automatic test_sweep();
        localparam int NS = 24;
        exp_t        q1 [$];
        exp_t        q2 [$];
        exp_t        q3 [$];
        int          iss [3];
        int          rcv [3];
        int          fc  [3];
        logic [63:0] a [3];
        logic [63:0] b [3];
        logic        s [3];
        logic        acc [3];
        logic        hs [3];
        for (int i = 0; i < 3; i++) begin
            iss[i] = 0;
            rcv[i] = 0;
            fc[i]  = -1;
            a[i]   = {$urandom, $urandom};
            b[i]   = {$urandom, $urandom};
            s[i]   = 1'($urandom % 2);
        end
        for (int cyc = 0; cyc < 600 &&
             (rcv[0] < NS || rcv[1] < NS || rcv[2] < NS); cyc++) begin
            if1.out_ready = (cyc < 12) || ($urandom % 4 != 0);
            if2.out_ready = (cyc < 12) || ($urandom % 4 != 0);
            if3.out_ready = (cyc < 12) || ($urandom % 4 != 0);
            if1.in_valid  = (iss[0] < NS);
            if2.in_valid  = (iss[1] < NS);
            if3.in_valid  = (iss[2] < NS);
            if1.in_op     = adder_op_t'(s[0]);
            if2.in_op     = adder_op_t'(s[1]);
            if3.in_op     = adder_op_t'(s[2]);
            if1.operand_a = a[0][31:0];
            if1.operand_b = b[0][31:0];
            if2.operand_a = a[1];
            if2.operand_b = b[1];
            if3.operand_a = a[2][7:0];
            if3.operand_b = b[2][7:0];
            #1;
            acc[0] = if1.in_valid & if1.in_ready;
            acc[1] = if2.in_valid & if2.in_ready;
            acc[2] = if3.in_valid & if3.in_ready;
            hs[0]  = if1.out_valid & if1.out_ready;
            hs[1]  = if2.out_valid & if2.out_ready;
            hs[2]  = if3.out_valid & if3.out_ready;
            if (hs[0]) begin
                nvec++;
                if (got1() !== q1[0]) begin
                    nerr++;
                    $display("FAIL sweep32x1_%0d got=%h want=%h",
                             rcv[0], got1(), q1[0]);
                end
                if (rcv[0] == 0) fc[0] = cyc;
                void'(q1.pop_front());
                rcv[0]++;
            end
            if (hs[1]) begin
                nvec++;
                if (got2() !== q2[0]) begin
                    nerr++;
                    $display("FAIL sweep64x8_%0d got=%h want=%h",
                             rcv[1], got2(), q2[0]);
                end
                if (rcv[1] == 0) fc[1] = cyc;
                void'(q2.pop_front());
                rcv[1]++;
            end
            if (hs[2]) begin
                nvec++;
                if (got3() !== q3[0]) begin
                    nerr++;
                    $display("FAIL sweep8x8_%0d got=%h want=%h",
                             rcv[2], got3(), q3[0]);
                end
                if (rcv[2] == 0) fc[2] = cyc;
                void'(q3.pop_front());
                rcv[2]++;
            end
            if (acc[0]) q1.push_back(model(32, s[0], a[0], b[0]));
            if (acc[1]) q2.push_back(model(64, s[1], a[1], b[1]));
            if (acc[2]) q3.push_back(model(8, s[2], a[2], b[2]));
            step();
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    iss[i]++;
                    a[i] = {$urandom, $urandom};
                    b[i] = {$urandom, $urandom};
                    s[i] = 1'($urandom % 2);
                end
            end
        end
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        if3.in_valid = 1'b0;
        nvec++;
        if (fc[0] != 1 || fc[1] != 8 || fc[2] != 8) begin
            nerr++;
            $display("FAIL sweep_latency got=%0d/%0d/%0d want=1/8/8",
                     fc[0], fc[1], fc[2]);
        end
        nvec++;
        if (rcv[0] != NS || rcv[1] != NS || rcv[2] != NS) begin
            nerr++;
            $display("FAIL sweep_count got=%0d/%0d/%0d want=%0d each",
                     rcv[0], rcv[1], rcv[2], NS);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0; if0.out_ready = 1'b1; if0.in_op = ADDER_OP_ADD;
        if0.operand_a = '0; if0.operand_b = '0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.in_op = ADDER_OP_ADD;
        if1.operand_a = '0; if1.operand_b = '0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b1; if2.in_op = ADDER_OP_ADD;
        if2.operand_a = '0; if2.operand_b = '0;
        if3.in_valid = 1'b0; if3.out_ready = 1'b1; if3.in_op = ADDER_OP_ADD;
        if3.operand_a = '0; if3.operand_b = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
